// File: rtl/pwm_capture_if.sv
// Measurement bus of the PWM capture block: PWM input towards the block, results back.
interface pwm_capture_if #(
    parameter int unsigned CTR_LEN = 8
);
    logic             pwm_in;
    logic [CTR_LEN:0] period;
    logic [CTR_LEN:0] high_time;
    logic             valid;
    logic             stuck_high;
    logic             stuck_low;

    modport master (
        output pwm_in,
        input  period, high_time, valid, stuck_high, stuck_low
    );

    modport slave (
        input  pwm_in,
        output period, high_time, valid, stuck_high, stuck_low
    );
endinterface

// File: rtl/pwm_capture.sv
// Measures period (rise to rise) and high time of an asynchronous PWM input in clk cycles,
// flagging a stuck-high or stuck-low input when rising edges stop arriving.
module pwm_capture #(
    parameter int unsigned CTR_LEN = 8,
    parameter int unsigned TIMEOUT = 2 ** (CTR_LEN + 1) - 1
) (
    input logic          clk,
    input logic          rst_n,
    pwm_capture_if.slave bus
);
    localparam int unsigned W = CTR_LEN + 1;
    localparam logic [W-1:0] CNT_MAX     = '1;
    localparam logic [W-1:0] CNT_ONE     = W'(1);
    localparam logic [W-1:0] CNT_TWO     = W'(2);
    localparam logic [W-1:0] TIMEOUT_CNT = W'(TIMEOUT);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARM     = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;
    localparam logic [1:0] STUCK   = 2'd3;

    logic         s1_q, s2_q, s3_q;
    logic         rise, fall, timeout;
    logic [W-1:0] per_cnt_q, per_cnt_d;
    logic [W-1:0] hi_cnt_q, hi_cnt_d;
    logic [1:0]   state_q, state_d;
    logic [W-1:0] period_q, period_d;
    logic [W-1:0] high_time_q, high_time_d;
    logic         valid_q, valid_d;
    logic         stuck_high_q, stuck_high_d;
    logic         stuck_low_q, stuck_low_d;

    assign rise    = s2_q & ~s3_q;
    assign fall    = ~s2_q & s3_q;
    assign timeout = (per_cnt_q == TIMEOUT_CNT) && !rise;

    always_comb begin
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        if (rise) begin
            per_cnt_d = CNT_ONE;
            hi_cnt_d  = CNT_ONE;
        end else begin
            if (per_cnt_q != CNT_MAX) per_cnt_d = per_cnt_q + CNT_ONE;
            if (s2_q && (hi_cnt_q != CNT_MAX)) hi_cnt_d = hi_cnt_q + CNT_ONE;
        end
    end

    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        valid_d      = 1'b0;
        stuck_high_d = stuck_high_q;
        stuck_low_d  = stuck_low_q;
        case (state_q)
            IDLE: begin
                // s2 only holds a real post-reset sample once per_cnt has reached 2;
                // this keeps an input that was already high at release from arming.
                if (timeout) begin
                    state_d      = STUCK;
                    stuck_high_d = s2_q;
                    stuck_low_d  = ~s2_q;
                end else if (!s2_q && (per_cnt_q >= CNT_TWO)) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (rise) begin
                    state_d = MEASURE;
                end else if (timeout) begin
                    state_d      = STUCK;
                    stuck_high_d = s2_q;
                    stuck_low_d  = ~s2_q;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_d    = per_cnt_q;
                    high_time_d = hi_cnt_q;
                    valid_d     = 1'b1;
                end else if (timeout) begin
                    state_d      = STUCK;
                    stuck_high_d = s2_q;
                    stuck_low_d  = ~s2_q;
                end
            end
            default: begin
                // The period containing the recovery rise is partial, so it is not reported.
                if (rise) begin
                    state_d      = MEASURE;
                    stuck_high_d = 1'b0;
                    stuck_low_d  = 1'b0;
                end else if (fall && stuck_high_q) begin
                    state_d      = ARM;
                    stuck_high_d = 1'b0;
                    stuck_low_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            per_cnt_q    <= '0;
            hi_cnt_q     <= '0;
            state_q      <= IDLE;
            period_q     <= '0;
            high_time_q  <= '0;
            valid_q      <= 1'b0;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
        end else begin
            s1_q         <= bus.pwm_in;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            per_cnt_q    <= per_cnt_d;
            hi_cnt_q     <= hi_cnt_d;
            state_q      <= state_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            valid_q      <= valid_d;
            stuck_high_q <= stuck_high_d;
            stuck_low_q  <= stuck_low_d;
        end
    end

    assign bus.period     = period_q;
    assign bus.high_time  = high_time_q;
    assign bus.valid      = valid_q;
    assign bus.stuck_high = stuck_high_q;
    assign bus.stuck_low  = stuck_low_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Randomized bench for pwm_capture: a timestamp-based reference model predicts reports into a
// scoreboard queue that a separate monitor drains whenever the DUT pulses valid.
module tb_pwm_capture;
    localparam int unsigned CTR_LEN = 8;
    localparam int TIMEOUT = 2 ** (CTR_LEN + 1) - 1;
    localparam int CNT_MAX = 2 ** (CTR_LEN + 1) - 1;
    localparam int GEN_PER = 2 ** CTR_LEN;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_capture_if #(.CTR_LEN(CTR_LEN)) bus ();

    pwm_capture #(
        .CTR_LEN(CTR_LEN),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int due;
        int per;
        int hi;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: input samples indexed by the post-reset clock edge that captured them.
    bit hist[$];
    int t;
    int last_rise;
    int ref_rise;
    bit armed;
    bit m_sh;
    bit m_sl;
    int gen_cnt = 0;

    function automatic bit h(input int k);
        if (k >= 1 && k <= hist.size()) return hist[k-1];
        return 1'b0;
    endfunction

    function automatic int count_high(input int a, input int b);
        int n = 0;
        for (int k = a; k <= b; k++) n += int'(h(k));
        return n;
    endfunction

    task automatic model_reset();
        hist.delete();
        exp_q.delete();
        t = 0;
        last_rise = 1;
        ref_rise = 0;
        armed = 1'b0;
        m_sh = 1'b0;
        m_sl = 1'b0;
    endtask

    // Called at a falling edge: drives the input for the next rising edge and predicts its effect.
    task automatic step(input bit x);
        bit s2, s3, rise, fall;
        int elapsed;
        bus.pwm_in = x;
        t++;
        hist.push_back(x);
        // An input edge reaches the detector two clock edges after it is first sampled.
        s2 = h(t - 2);
        s3 = h(t - 3);
        rise = s2 & ~s3;
        fall = ~s2 & s3;
        elapsed = t - last_rise;
        if (elapsed > CNT_MAX) elapsed = CNT_MAX;
        if (rise) begin
            if (armed && !(m_sh || m_sl) && ref_rise > 0 && (t - ref_rise) <= TIMEOUT)
                exp_q.push_back('{cyc + 1, t - ref_rise, count_high(ref_rise - 2, t - 3)});
            if (armed) ref_rise = t;
            m_sh = 1'b0;
            m_sl = 1'b0;
            last_rise = t;
        end else if (!(m_sh || m_sl) && elapsed == TIMEOUT) begin
            m_sh = s2;
            m_sl = ~s2;
            armed = 1'b1;
        end else if (m_sh && fall) begin
            m_sh = 1'b0;
        end else if (!armed && !s2 && elapsed >= 2) begin
            armed = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic gen(input int compare, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step(gen_cnt < compare);
            gen_cnt = (gen_cnt + 1) % GEN_PER;
        end
    endtask

    task automatic wave(input int per, input int hi, input int n);
        for (int p = 0; p < n; p++)
            for (int i = 0; i < per; i++) step(i < hi);
    endtask

    task automatic do_reset(input bit level, input int hold);
        @(negedge clk);
        bus.pwm_in = level;
        rst_n = 1'b0;
        repeat (hold) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic check_zero(input string name, input int act);
        checks++;
        if (act != 0) begin
            errors++;
            $display("FAIL %s: got %0d, expected 0", name, act);
        end
    endtask

    initial begin : monitor
        bit prev_valid = 1'b0;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                if (bus.valid) begin
                    checks++;
                    if (prev_valid) begin
                        errors++;
                        $display("FAIL valid_width: valid high 2 cycles at cyc %0d, expected 1", cyc);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_valid: period=%0d high=%0d at cyc %0d, expected none",
                                 bus.period, bus.high_time, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.due != cyc || int'(bus.period) != e.per || int'(bus.high_time) != e.hi) begin
                            errors++;
                            $display("FAIL report: got cyc=%0d period=%0d high=%0d, expected cyc=%0d period=%0d high=%0d",
                                     cyc, bus.period, bus.high_time, e.due, e.per, e.hi);
                        end
                    end
                end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    checks++;
                    errors++;
                    e = exp_q.pop_front();
                    $display("FAIL missing_valid: none at cyc %0d, expected period=%0d high=%0d",
                             cyc, e.per, e.hi);
                end
                checks++;
                if (bus.stuck_high !== m_sh || bus.stuck_low !== m_sl) begin
                    errors++;
                    $display("FAIL stuck_flags: got hi=%b lo=%b at cyc %0d, expected hi=%b lo=%b",
                             bus.stuck_high, bus.stuck_low, cyc, m_sh, m_sl);
                end
                prev_valid = bus.valid;
            end
        end
    end

    initial begin : stimulus
        int per;
        bus.pwm_in = 1'b0;
        model_reset();
        #1;
        check_zero("reset_period", int'(bus.period));
        check_zero("reset_high_time", int'(bus.high_time));
        check_zero("reset_valid", int'(bus.valid));
        check_zero("reset_stuck", int'(bus.stuck_high) + int'(bus.stuck_low));

        // Generator-style duty cycles, including the extreme compares.
        do_reset(1'b0, 3);
        gen_cnt = 0;
        gen(64, GEN_PER * 6);
        gen(255, GEN_PER * 4);
        gen(1, GEN_PER * 4);

        // Held low after reset, then recovery.
        do_reset(1'b0, 3);
        repeat (600) step(1'b0);
        gen_cnt = 0;
        gen(128, GEN_PER * 4);

        // Held high through reset release, then recovery.
        do_reset(1'b1, 3);
        repeat (700) step(1'b1);
        gen_cnt = 200;
        gen(32, GEN_PER * 5);

        // Rise landing exactly on the timeout, one cycle beyond it, and the fastest legal rate.
        wave(TIMEOUT, 100, 4);
        wave(TIMEOUT + 1, 50, 3);
        wave(2, 1, 12);
        wave(3, 2, 6);

        // Asynchronous reset between clock edges while the input is high mid-pulse.
        gen_cnt = 0;
        gen(96, GEN_PER * 2 + 40);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_period", int'(bus.period));
        check_zero("async_high_time", int'(bus.high_time));
        check_zero("async_valid", int'(bus.valid));
        check_zero("async_stuck", int'(bus.stuck_high) + int'(bus.stuck_low));
        repeat (3) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        gen(96, GEN_PER * 4);

        // Random generator compares and arbitrary periods.
        for (int s = 0; s < 20; s++) begin
            if ($urandom_range(1, 0) == 1) begin
                gen($urandom_range(255, 1), GEN_PER * 3);
            end else begin
                per = $urandom_range(TIMEOUT, 2);
                wave(per, $urandom_range(per - 1, 1), 3);
            end
        end

        repeat (8) step(1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d reports outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
